// File: rtl/eim_burst_bridge.sv
// EIM multiplexed address/data burst bridge onto a single-clock internal register bus.
// Generates linear or wrapping beat addresses, drives WAIT on backpressure, flags overruns.
module eim_burst_bridge #(
   parameter int unsigned DW         = 16,
   parameter int unsigned AHW        = 3,
   parameter int unsigned CS_SEL     = 1,
   parameter int unsigned MAX_BURST  = 32,
   parameter int unsigned BURST_WRAP = 0,
   parameter int unsigned WAIT_EN    = 1
) (
   input  logic              bus_clk,
   input  logic              reset,
   input  logic [1:0]        eim_cs_n,
   input  logic              eim_lba_n,
   input  logic              eim_rw_n,
   input  logic              eim_oe_n,
   input  logic [AHW-1:0]    eim_a_hi,
   input  logic [DW-1:0]     eim_din,
   output logic [DW-1:0]     eim_dout,
   output logic              eim_dout_oe,
   output logic              eim_wait_n,
   output logic [AHW+DW-1:0] bus_addr,
   output logic              bus_sel,
   output logic              bus_wr,
   output logic [DW-1:0]     bus_data_wr,
   input  logic [DW-1:0]     bus_data_rd,
   input  logic              bus_rdy,
   output logic              burst_err
);

   localparam int unsigned AW = AHW + DW;
   localparam int unsigned LB = $clog2(MAX_BURST);
   localparam int unsigned CW = LB + 1;

   typedef enum logic [1:0] {StIdle, StAddr, StData} state_t;

   state_t          state;
   logic            dir_rd;
   logic [CW-1:0]   beat_cnt;
   logic            cs;
   logic            accept;
   logic            stall;
   logic [AW-1:0]   addr_next;

   assign cs     = !eim_cs_n[CS_SEL];
   assign accept = bus_sel && (bus_rdy || (WAIT_EN == 0));
   assign stall  = bus_sel && !bus_rdy && (WAIT_EN != 0);

   // In wrap mode only the offset inside the MAX_BURST-aligned window advances.
   always_comb begin
      addr_next = bus_addr + AW'(1);
      if (BURST_WRAP != 0) begin
         addr_next = bus_addr;
         addr_next[LB-1:0] = bus_addr[LB-1:0] + LB'(1);
      end
   end

   always_ff @(posedge bus_clk) begin
      if (reset) begin
         state       <= StIdle;
         dir_rd      <= 1'b0;
         beat_cnt    <= '0;
         bus_sel     <= 1'b0;
         bus_wr      <= 1'b0;
         bus_addr    <= '0;
         bus_data_wr <= '0;
         eim_dout    <= '0;
         eim_dout_oe <= 1'b0;
         eim_wait_n  <= 1'b1;
         burst_err   <= 1'b0;
      end else begin
         eim_dout_oe <= !eim_oe_n && eim_lba_n && cs && dir_rd;

         // Acceptance is a fact on the bus even in an abort cycle, so account for it first.
         if (accept) begin
            if (beat_cnt == CW'(MAX_BURST)) begin
               burst_err <= 1'b1;
            end else begin
               beat_cnt <= beat_cnt + CW'(1);
            end
            bus_addr <= addr_next;
            if (!bus_wr) begin
               eim_dout <= bus_data_rd;
            end
         end

         if (!cs) begin
            state      <= StIdle;
            bus_sel    <= 1'b0;
            eim_wait_n <= 1'b1;
         end else if (!eim_lba_n) begin
            state      <= StAddr;
            bus_addr   <= {eim_a_hi, eim_din};
            dir_rd     <= eim_rw_n;
            beat_cnt   <= '0;
            bus_sel    <= 1'b0;
            eim_wait_n <= 1'b1;
         end else if (state != StIdle) begin
            state <= StData;
            // While stalled the host holds its pending beat, so din is not sampled.
            if (stall) begin
               eim_wait_n <= 1'b0;
            end else begin
               bus_sel     <= 1'b1;
               bus_wr      <= !dir_rd;
               bus_data_wr <= eim_din;
               eim_wait_n  <= 1'b1;
            end
         end
      end
   end

endmodule
